// File: rtl/half_matrix_loader.sv
// Assembles a stream of binary16 elements into a WIDTH x HEIGHT matrix, row-major,
// and holds it for the downstream stage until consumed. Single-buffered.
module half_matrix_loader #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned HEIGHT = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [15:0]                          in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [WIDTH-1:0][HEIGHT-1:0][15:0]   m_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 frame_err
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned JW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [IW-1:0] IMax = IW'(WIDTH - 1);
    localparam logic [JW-1:0] JMax = JW'(HEIGHT - 1);

    typedef enum logic {StLoad, StFull} state_e;

    state_e                             state_q, state_d;
    logic [IW-1:0]                      i_q, i_d;
    logic [JW-1:0]                      j_q, j_d;
    logic                               err_q, err_d;
    logic                               wr_en;
    logic                               is_last;
    logic [WIDTH-1:0][HEIGHT-1:0][15:0] m_q;

    assign is_last   = (i_q == IMax) && (j_q == JMax);
    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StFull);
    assign frame_err = err_q;
    assign m_out     = m_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            StLoad: begin
                if (in_valid) begin
                    if (is_last) begin
                        wr_en   = 1'b1;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = StFull;
                        if (!in_last) err_d = 1'b1;
                    end else if (in_last) begin
                        // Early in_last: drop the partial frame and restart at [0][0].
                        i_d   = '0;
                        j_d   = '0;
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (j_q == JMax) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            StFull: begin
                if (out_ready) state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            i_q     <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            err_q   <= err_d;
            if (wr_en) m_q[i_q][j_q] <= in_data;
        end
    end

endmodule
